// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// fetch_stage_if : hazard, instruction-memory and IF/ID signals of the fetch stage
// Revision 1.0
// ============================================================================
interface fetch_stage_if;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [15:0] stall_cnt;

    modport master (
        input  stall, flush, branch_target, imem_valid, imem_rdata,
        output imem_req, imem_addr, id_pc, id_inst, id_valid, stall_cnt
    );

    modport slave (
        output stall, flush, branch_target, imem_valid, imem_rdata,
        input  imem_req, imem_addr, id_pc, id_inst, id_valid, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : instruction fetch with one-word skid buffer and squash drain
// Revision 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_FULL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_inst;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic        r_imem_req;
    logic [31:0] r_imem_addr;
    logic [15:0] r_stall_cnt;

    state_t      w_state;
    logic [31:0] w_pc;
    logic [31:0] w_drain_addr;
    logic [31:0] w_buf_pc;
    logic [31:0] w_buf_inst;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_inst;
    logic        w_id_valid;
    logic [31:0] w_pc_inc;
    logic [31:0] w_target;
    logic        w_cnt_inc;

    assign w_pc_inc  = r_pc + 32'd4;
    assign w_target  = bus.branch_target & ~32'h0000_0003;
    assign w_cnt_inc = bus.stall && !bus.flush && (r_stall_cnt != c_CNT_MAX);

    always_comb begin
        w_state      = r_state;
        w_pc         = r_pc;
        w_drain_addr = r_drain_addr;
        w_buf_pc     = r_buf_pc;
        w_buf_inst   = r_buf_inst;
        w_id_pc      = r_id_pc;
        w_id_inst    = r_id_inst;
        w_id_valid   = r_id_valid;

        if (bus.flush) begin
            // Squash: bubble into IF/ID, keep id_pc, redirect
            w_id_inst  = NOP_INST;
            w_id_valid = 1'b0;
            w_pc       = w_target;
            case (r_state)
                S_REQ: begin
                    if (bus.imem_valid) begin
                        w_state = S_REQ;
                    end else begin
                        w_state      = S_DRAIN;
                        w_drain_addr = r_pc;
                    end
                end
                S_FULL:  w_state = S_REQ;
                S_DRAIN: w_state = bus.imem_valid ? S_REQ : S_DRAIN;
                default: w_state = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.imem_valid) begin
                        if (bus.stall) begin
                            w_buf_pc   = r_pc;
                            w_buf_inst = bus.imem_rdata;
                            w_state    = S_FULL;
                        end else begin
                            w_id_pc    = r_pc;
                            w_id_inst  = bus.imem_rdata;
                            w_id_valid = 1'b1;
                            w_pc       = w_pc_inc;
                        end
                    end else if (!bus.stall) begin
                        w_id_inst  = NOP_INST;
                        w_id_valid = 1'b0;
                    end
                end
                S_FULL: begin
                    if (!bus.stall) begin
                        w_id_pc    = r_buf_pc;
                        w_id_inst  = r_buf_inst;
                        w_id_valid = 1'b1;
                        w_pc       = w_pc_inc;
                        w_state    = S_REQ;
                    end
                end
                S_DRAIN: begin
                    // The stale response is swallowed here and never reaches IF/ID
                    if (!bus.stall) begin
                        w_id_inst  = NOP_INST;
                        w_id_valid = 1'b0;
                    end
                    if (bus.imem_valid) begin
                        w_state = S_REQ;
                    end
                end
                default: w_state = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_drain_addr <= 32'h0;
            r_buf_pc     <= 32'h0;
            r_buf_inst   <= NOP_INST;
            r_id_pc      <= 32'h0;
            r_id_inst    <= NOP_INST;
            r_id_valid   <= 1'b0;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= RESET_PC;
            r_stall_cnt  <= 16'h0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_drain_addr <= w_drain_addr;
            r_buf_pc     <= w_buf_pc;
            r_buf_inst   <= w_buf_inst;
            r_id_pc      <= w_id_pc;
            r_id_inst    <= w_id_inst;
            r_id_valid   <= w_id_valid;
            // Request outputs are registered from the next state so they stay low during reset
            r_imem_req   <= (w_state != S_FULL);
            r_imem_addr  <= (w_state == S_DRAIN) ? w_drain_addr : w_pc;
            if (w_cnt_inc) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_imem_addr;
    assign bus.id_pc     = r_id_pc;
    assign bus.id_inst   = r_id_inst;
    assign bus.id_valid  = r_id_valid;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, encoding placed in id_inst for a bubble.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port stall  input  1  from hazard unit; hold IF/ID and PC this cycle.
REQ-006 Port flush  input  1  from hazard unit (branch taken); squash IF/ID and redirect PC.
REQ-007 Port branch_target  input  32  redirect address, sampled when flush=1.
REQ-008 Port imem_req  output  1  instruction memory request, held until imem_valid.
REQ-009 Port imem_addr  output  32  fetch address, stable while imem_req=1.
REQ-010 Port imem_valid  input  1  one-cycle response strobe, exactly one per request.
REQ-011 Port imem_rdata  input  32  instruction word, valid with imem_valid.
REQ-012 Port id_pc  output  32  IF/ID register: PC of id_inst.
REQ-013 Port id_inst  output  32  IF/ID register: instruction or NOP_INST.
REQ-014 Port id_valid  output  1  IF/ID register holds a real instruction.
REQ-015 Port stall_cnt  output  16  saturating count of cycles with stall=1 and flush=0.

Function
REQ-016 FSM states: REQ (request outstanding), FULL (one fetched word buffered, no request), DRAIN (discarding the response to a squashed request).
REQ-017 imem_req shall be 1 in REQ and DRAIN, 0 in FULL; imem_addr shall equal the internal PC in REQ and the squashed address in DRAIN.
REQ-018 PC increment shall be +4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 branch_target[1:0] shall be forced to 2'b00 when loaded into PC.
REQ-020 REQ, imem_valid=1, stall=0, flush=0: IF/ID <= {PC, imem_rdata, valid=1}, PC <= PC+4, stay REQ (back-to-back requests allowed).
REQ-021 REQ, imem_valid=1, stall=1, flush=0: word and PC captured in buffer, IF/ID unchanged, go FULL.
REQ-022 REQ, imem_valid=0, stall=0, flush=0: IF/ID <= bubble (id_valid=0, id_inst=NOP_INST, id_pc unchanged).
REQ-023 Any state, stall=1, flush=0, no IF/ID load per REQ-020: IF/ID and PC unchanged.
REQ-024 FULL, stall=0, flush=0: IF/ID <= buffer contents with valid=1, PC <= PC+4, go REQ.
REQ-025 flush=1 has priority over stall and imem_valid in every state.
REQ-026 flush=1: IF/ID <= bubble, buffer discarded, PC <= branch_target.
REQ-027 flush=1 in REQ with imem_valid=0: go DRAIN, holding the squashed address on imem_addr.
REQ-028 flush=1 in REQ with imem_valid=1, or in FULL: response/buffer discarded, go REQ at new PC next cycle.
REQ-029 DRAIN: imem_valid=1 discarded (never reaches IF/ID), go REQ; flush=1 in DRAIN updates PC again, stays DRAIN unless imem_valid=1.
REQ-030 stall_cnt shall increment on stall=1 and flush=0, saturate at 16'hFFFF, and never wrap.

Reset
REQ-031 While reset_n=0: state=REQ, PC=RESET_PC, buffer empty, id_pc=0, id_inst=NOP_INST, id_valid=0, stall_cnt=0.
REQ-032 While reset_n=0, imem_req shall be 0; after release, imem_req=1 with imem_addr=RESET_PC at the first rising edge.
REQ-033 Reset mid-request or in DRAIN shall abandon the transaction; a response arriving in the first cycle after release shall be accepted as the RESET_PC fetch.

Verification
REQ-034 Zero-wait memory, no hazards, 4 cycles -> id_pc 0,4,8,C with id_valid=1 on consecutive cycles.
REQ-035 Response 32'h00A00093 at PC 8 with stall=1 for 2 cycles -> state FULL, imem_req=0, IF/ID holds PC 4; after stall drops id_pc=8, id_inst=32'h00A00093; stall_cnt=2.
REQ-036 flush=1, branch_target=32'h0000_0103 while request to 32'h10 outstanding -> DRAIN; the late response to 32'h10 is dropped; next imem_addr=32'h0000_0100; id_valid=0 during drain.
REQ-037 flush=1 and stall=1 with imem_valid=1 in same cycle -> bubble in IF/ID, PC=branch_target, stall_cnt unchanged.
REQ-038 PC=32'hFFFF_FFFC fetched without stall -> next imem_addr=32'h0000_0000.
REQ-039 Hold stall=1 for 70000 cycles -> stall_cnt=16'hFFFF and remains there.
